// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential multiplier.
// Operand/product widths, last iteration index and FSM state encoding.
package arith_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    localparam logic [5:0] ITER_LAST = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_64bit.sv
// 64-bit ripple-carry adder, purely combinational.
// Ports: a, b (64) addends; c_in carry in; sum (64); c_out carry out.
module RCA_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] sum,
    output logic        c_out
);

    logic [64:0] w_c;

    assign w_c[0] = c_in;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_fa
            assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a[gi] & b[gi])
                              | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = w_c[64];

endmodule

// File: rtl/seq_mult_32x32.sv
// Unsigned 32x32->64 shift-and-add multiplier, one add per clock.
// Ports: clk, rst (sync, active-high), start, a, b in; busy, done, product out.
module seq_mult_32x32
    import arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t              r_state;
    logic [PROD_W-1:0]   r_mcand;
    logic [OP_W-1:0]     r_mplier;
    logic [PROD_W-1:0]   r_acc;
    logic [5:0]          r_cnt;
    logic [PROD_W-1:0]   r_product;

    logic [PROD_W-1:0]   w_addend;
    logic [PROD_W-1:0]   w_sum;
    // Carry out can never be set: the final product fits in 64 bits.
    logic                w_unused_cout;

    assign w_addend = r_mplier[0] ? r_mcand : '0;

    RCA_64bit u_rca (
        .a     (r_acc),
        .b     (w_addend),
        .c_in  (1'b0),
        .sum   (w_sum),
        .c_out (w_unused_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RUN;
                        r_mcand  <= {{(PROD_W-OP_W){1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 6'd1;
                    // Product register is loaded only on the way into DONE.
                    if (r_cnt == ITER_LAST) begin
                        r_state   <= DONE;
                        r_product <= w_sum;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule
